// File: rtl/pipeline_wb_chain.sv
// Write-back pipeline chain of DEPTH register stages. It provides flush/stall control,
// a forwarding lookup across all stages, and a retired-write counter.
module pipeline_wb_chain #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [1:0]        WB_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [REG_AW-1:0] RegDst_i,
  input  logic [REG_AW-1:0] fwd_a_i,
  input  logic [REG_AW-1:0] fwd_b_i,
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] addr_o,
  output logic [REG_AW-1:0] RegDst_o,
  output logic [DATA_W-1:0] wbdata_o,
  output logic              fwd_a_hit_o,
  output logic              fwd_b_hit_o,
  output logic [DATA_W-1:0] fwd_a_data_o,
  output logic [DATA_W-1:0] fwd_b_data_o,
  output logic [15:0]       retired_o
);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             rw_q, rw_d;
  logic [DEPTH-1:0]             m2r_q, m2r_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0][DATA_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][REG_AW-1:0] dst_q, dst_d;
  logic [15:0]                  retired_q, retired_d;

  function automatic logic [DATA_W-1:0] wb_value(input logic m2r,
                                                 input logic [DATA_W-1:0] d,
                                                 input logic [DATA_W-1:0] a);
    return m2r ? d : a;
  endfunction

  assign valid_o    = valid_q[DEPTH-1];
  assign RegWrite_o = valid_q[DEPTH-1] & rw_q[DEPTH-1] & (dst_q[DEPTH-1] != '0);
  assign MemtoReg_o = valid_q[DEPTH-1] & m2r_q[DEPTH-1];
  assign data_o     = data_q[DEPTH-1];
  assign addr_o     = addr_q[DEPTH-1];
  assign RegDst_o   = dst_q[DEPTH-1];
  assign wbdata_o   = wb_value(m2r_q[DEPTH-1], data_q[DEPTH-1], addr_q[DEPTH-1]);
  assign retired_o  = retired_q;

  // Stored control bits are gated by valid so an invalid slot never carries a write.
  always_comb begin
    valid_d   = valid_q;
    rw_d      = rw_q;
    m2r_d     = m2r_q;
    data_d    = data_q;
    addr_d    = addr_q;
    dst_d     = dst_q;
    retired_d = retired_q;
    if (flush_i) begin
      valid_d = '0;
      rw_d    = '0;
      m2r_d   = '0;
    end else if (!stall_i) begin
      valid_d[0] = valid_i;
      rw_d[0]    = valid_i & WB_i[1];
      m2r_d[0]   = valid_i & WB_i[0];
      data_d[0]  = data_i;
      addr_d[0]  = addr_i;
      dst_d[0]   = RegDst_i;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        rw_d[k]    = rw_q[k-1];
        m2r_d[k]   = m2r_q[k-1];
        data_d[k]  = data_q[k-1];
        addr_d[k]  = addr_q[k-1];
        dst_d[k]   = dst_q[k-1];
      end
      if (RegWrite_o) begin
        retired_d = retired_q + 16'd1;
      end else begin
        retired_d = retired_q;
      end
    end else begin
      retired_d = retired_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      rw_q      <= '0;
      m2r_q     <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      dst_q     <= '0;
      retired_q <= 16'd0;
    end else begin
      valid_q   <= valid_d;
      rw_q      <= rw_d;
      m2r_q     <= m2r_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      dst_q     <= dst_d;
      retired_q <= retired_d;
    end
  end

  // Scan oldest to youngest so the youngest qualifying stage overwrites last.
  always_comb begin
    fwd_a_hit_o  = 1'b0;
    fwd_b_hit_o  = 1'b0;
    fwd_a_data_o = '0;
    fwd_b_data_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && rw_q[k] && (dst_q[k] == fwd_a_i) && (fwd_a_i != '0)) begin
        fwd_a_hit_o  = 1'b1;
        fwd_a_data_o = wb_value(m2r_q[k], data_q[k], addr_q[k]);
      end else begin
        fwd_a_hit_o  = fwd_a_hit_o;
      end
      if (valid_q[k] && rw_q[k] && (dst_q[k] == fwd_b_i) && (fwd_b_i != '0)) begin
        fwd_b_hit_o  = 1'b1;
        fwd_b_data_o = wb_value(m2r_q[k], data_q[k], addr_q[k]);
      end else begin
        fwd_b_hit_o  = fwd_b_hit_o;
      end
    end
  end

endmodule
